// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared widths, FSM states and response record for the ALU sequencing arbiter
package alu_seq_pkg;
  localparam int OPW = 4;
  localparam int OPCW = 3;
  localparam int BCDW = 12;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef struct packed {
    logic            id;
    logic [BCDW-1:0] y;
    logic            cout;
    logic            ovf;
  } resp_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant; on a tie the requester that did not win last time gets it
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic       grant
);
  always_comb grant = &valid ? ~last : valid[1];
endmodule

// File: rtl/alu_seq_arbiter.sv
// alu_seq_arbiter: shares one BCD ALU between two requesters with round-robin grant and a backpressured response.
// Optional saturating overflow counter enabled by `define ALU_SEQ_OVFCNT_EN.
module alu_seq_arbiter
  import alu_seq_pkg::*;
#(
  parameter int ALU_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [OPW-1:0]  req0_a,
  input  logic [OPW-1:0]  req0_b,
  input  logic [OPCW-1:0] req0_op,
  input  logic            req0_cin,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [OPW-1:0]  req1_a,
  input  logic [OPW-1:0]  req1_b,
  input  logic [OPCW-1:0] req1_op,
  input  logic            req1_cin,
  output logic [OPW-1:0]  alu_a,
  output logic [OPW-1:0]  alu_b,
  output logic [OPCW-1:0] alu_op,
  output logic            alu_cin,
  input  logic [BCDW-1:0] alu_bcd,
  input  logic            alu_cout,
  input  logic            alu_ovf,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [BCDW-1:0] rsp_y,
  output logic            rsp_cout,
  output logic            rsp_ovf
`ifdef ALU_SEQ_OVFCNT_EN
  ,
  output logic [7:0]      ovf_count
`endif
);
  localparam int CW = ALU_LAT > 1 ? $clog2(ALU_LAT) : 1;
  state_t        state;
  logic [CW-1:0] cnt;
  logic          last;
  logic          id;
  logic          grant;
  resp_t         rsp;
  rr_arb2 u_arb (
    .valid({req1_valid, req0_valid}),
    .last (last),
    .grant(grant)
  );
  // No accept while reset is held, so nothing is granted during the reset cycles.
  always_comb begin
    req0_ready = !rst && state == IDLE && !grant && req0_valid;
    req1_ready = !rst && state == IDLE && grant && req1_valid;
  end
  assign rsp_id   = rsp.id;
  assign rsp_y    = rsp.y;
  assign rsp_cout = rsp.cout;
  assign rsp_ovf  = rsp.ovf;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      last      <= 1'b1;
      id        <= 1'b0;
      rsp       <= '0;
      rsp_valid <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      alu_cin   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req0_ready || req1_ready) begin
          alu_a   <= grant ? req1_a : req0_a;
          alu_b   <= grant ? req1_b : req0_b;
          alu_op  <= grant ? req1_op : req0_op;
          alu_cin <= grant ? req1_cin : req0_cin;
          id      <= grant;
          last    <= grant;
          cnt     <= CW'(ALU_LAT - 1);
          state   <= WAIT;
        end
        WAIT: if (cnt == '0) begin
          rsp       <= '{id, alu_bcd, alu_cout, alu_ovf};
          rsp_valid <= 1'b1;
          state     <= RESP;
        end else begin
          cnt <= cnt - 1'b1;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef ALU_SEQ_OVFCNT_EN
  always_ff @(posedge clk) begin
    if (rst) ovf_count <= '0;
    else if (state == WAIT && cnt == '0 && alu_ovf && ovf_count != 8'hFF) ovf_count <= ovf_count + 1'b1;
  end
`endif
endmodule
